clk_step_gen: RTL

CLK_STEP_GEN -- requirements
Module: clk_step_gen

---
 rtl/clk_step_gen.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/clk_step_gen.sv
// Multi-channel clock divider with run / halt / single-step control,
// glitch-free divider reprogramming and a heartbeat output.
module clk_step_gen #(
    parameter  int unsigned NCH     = 2,
    parameter  int unsigned CW      = 32,
    parameter  int unsigned DEF_DIV = 1,
    parameter  int unsigned LED_DIV = 1,
    localparam int unsigned CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_in,
    input  logic           reset,
    input  logic [1:0]     mode,
    input  logic           step_req,
    input  logic [7:0]     step_cnt,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick,
    output logic           busy,
    output logic           led
);

    localparam int unsigned LED_N = (LED_DIV == 0) ? 1 : LED_DIV;
    localparam int unsigned LEDW  = (LED_N > 1) ? $clog2(LED_N) : 1;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED,
        ST_STEP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt  [NCH];
    logic [CW-1:0]   r_div  [NCH];
    logic [CW-1:0]   r_pdiv [NCH];
    logic [NCH-1:0]  r_pend;
    logic [NCH-1:0]  r_clk;
    logic [NCH-1:0]  r_tick;
    logic [7:0]      r_rem;
    logic            r_busy;
    logic            r_led;
    logic [LEDW-1:0] r_led_cnt;

    logic            w_en;
    logic [CW-1:0]   w_eff [NCH];
    logic [NCH-1:0]  w_wrap;
    logic            w_fall0;
    logic            w_rise0;
    logic            w_cfg_ready;
    logic            w_cfg_acc;
    logic            w_rem_load;
    logic            w_rem_dec;

    assign w_en    = (r_state != ST_HALTED);
    assign w_fall0 = w_wrap[0] & r_clk[0];
    assign w_rise0 = w_wrap[0] & ~r_clk[0];

    // Per-channel wrap detect; a programmed ratio of 0 behaves as 1
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_eff[i]  = (r_div[i] == '0) ? CW'(1) : r_div[i];
            w_wrap[i] = w_en && (r_cnt[i] == (w_eff[i] - CW'(1)));
        end
    end

    // Out-of-range channels never match, so they stay ready and are dropped
    always_comb begin
        w_cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CHW'(i)) begin
                w_cfg_ready = ~r_pend[i];
            end
        end
    end

    assign w_cfg_acc = cfg_valid & w_cfg_ready;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stopping only ever completes with clk_out[0] low; a rise in the
    // request cycle is drained like an already-high clock.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_load  = 1'b0;
        w_rem_dec   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (mode != MODE_RUN) begin
                    w_state_nxt = (r_clk[0] || w_rise0) ? ST_DRAIN : ST_HALTED;
                end
            end
            ST_DRAIN: begin
                if (mode == MODE_RUN) begin
                    w_state_nxt = ST_RUN;
                end else if (w_fall0) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (mode == MODE_RUN) begin
                    w_state_nxt = ST_RUN;
                end else if (step_req && (mode == MODE_STEP)) begin
                    w_state_nxt = ST_STEP;
                    w_rem_load  = 1'b1;
                end
            end
            default: begin
                if (mode == MODE_RUN) begin
                    w_state_nxt = ST_RUN;
                end else if (w_fall0) begin
                    w_rem_dec = 1'b1;
                    if (r_rem <= 8'd1) begin
                        w_state_nxt = ST_HALTED;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_rem  <= 8'd0;
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == ST_STEP);
            if (w_rem_load) begin
                r_rem <= (step_cnt == 8'd0) ? 8'd1 : step_cnt;
            end else if (w_rem_dec) begin
                r_rem <= r_rem - 8'd1;
            end
        end
    end

    // New ratios take effect only at a wrap, so no phase is ever shortened
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i]  <= '0;
                r_div[i]  <= CW'(DEF_DIV);
                r_pdiv[i] <= '0;
            end
            r_pend <= '0;
            r_clk  <= '0;
            r_tick <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_tick[i] <= w_wrap[i] & ~r_clk[i];
                if (w_wrap[i]) begin
                    r_cnt[i] <= '0;
                    r_clk[i] <= ~r_clk[i];
                    if (r_pend[i]) begin
                        r_div[i]  <= r_pdiv[i];
                        r_pend[i] <= 1'b0;
                    end
                end else if (w_en) begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
                if (w_cfg_acc && (cfg_ch == CHW'(i))) begin
                    r_pend[i] <= 1'b1;
                    r_pdiv[i] <= cfg_div;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_led     <= 1'b0;
            r_led_cnt <= '0;
        end else if (w_rise0) begin
            if (r_led_cnt == LEDW'(LED_N - 1)) begin
                r_led_cnt <= '0;
                r_led     <= ~r_led;
            end else begin
                r_led_cnt <= r_led_cnt + LEDW'(1);
            end
        end
    end

    assign cfg_ready = w_cfg_ready;
    assign clk_out   = r_clk;
    assign tick      = r_tick;
    assign busy      = r_busy;
    assign led       = r_led;

endmodule
